stream_mux_n: RTL and testbench
===============================

Name: stream_mux_n

Overview:
- Parametrised successor to the combinational 2:1 mux: an N-input, WIDTH-bit valid/ready stream multiplexer with a registered output stage.
- Channel choice is either an explicit select input or a built-in round-robin arbiter, chosen by a mode input.
- Sits between multiple producer streams and a single consumer, e.g. merging channel traffic into one datapath.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- SEL_W, $clog2(NUM_CH) (minimum 1), width of sel and out_ch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = MODE_SEL (sel port chooses the channel), 1 = MODE_RR (round-robin).
- sel  input  SEL_W  channel select; used in MODE_SEL only.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts a beat.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1. in_ready is combinational and is 0 while out_valid is low only if no grant exists.
- load_en = !out_valid || out_ready. This gives full throughput: one beat per cycle when out_ready is held high.
- Grant (combinational, at most one channel):
  - MODE_SEL: grant = sel if sel < NUM_CH, otherwise no grant.
  - MODE_RR: grant is the first i with in_valid[i], searching from rr_ptr+1 upward and wrapping modulo NUM_CH. No grant if no input is valid.
- in_ready[i] = load_en && grant is i. in_ready is asserted independently of in_valid in MODE_SEL; this is a valid/ready-compliant look-ahead.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next rising edge: out_data = channel i data, out_ch = i, out_valid = 1, and (MODE_RR only) rr_ptr = i.
- If load_en is high and no transfer occurs, out_valid drops to 0. out_data and out_ch hold their previous values.
- If out_valid && !out_ready (stall), the output register holds, all in_ready are 0, and rr_ptr holds.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Changing mode or sel mid-stream takes effect on the next load_en cycle only. Beats already in the output register are unaffected.
- rr_ptr is not updated in MODE_SEL. On switching to MODE_RR, the search starts from the stored rr_ptr.
- Reset asserted mid-transfer: the beat is dropped and out_valid is 0 immediately (async).

Optional Feature:
- Macro: STREAM_MUX_STATS_EN.
- When defined:
  - Adds input stat_clr (1 bit, synchronous clear).
  - Adds output stat_cnt (NUM_CH*16 bits): one 16-bit saturating counter per channel, incremented on each input transfer and holding at 16'hFFFF.
  - stat_clr takes priority over increment in the same cycle.
  - Counters reset to 0.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_e.
  - localparam STAT_CNT_W = 16.
- One sub-module, rr_arbiter (parameter NUM_CH):
  - Inputs: req[NUM_CH], last_ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority search.
- rr_ptr and the output register stay in stream_mux_n.

Test Plan (NUM_CH=4, WIDTH=8):
- MODE_SEL, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- MODE_RR after reset, in_valid=4'b1111 held, data chN=8'h10+N, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- Stall: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> in_ready=4'b0000, out_data and out_ch stable. out_ready=1 -> ch1 beat loaded on the following edge.
- MODE_RR with only ch3 valid, then ch0 and ch3 both valid -> ch3 is granted first, then ch0 (wrap from rr_ptr=3), then ch3.
- MODE_SEL with NUM_CH=3 and sel=3 (out of range), all in_valid=1 -> in_ready=0 and out_valid falls to 0 after draining.
- rst_n pulsed low for 2 ns mid-stream -> out_valid=0 asynchronously. After release, in MODE_RR the first grant is ch0. With STREAM_MUX_STATS_EN, 5 ch0 transfers give stat_cnt[15:0]=5; stat_clr=1 gives 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N:1 valid/ready stream mux.
// Holds the mode encoding, the stats counter width and the select-width helper.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  localparam int STAT_CNT_W = 16;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr.sv
// rr_arbiter: combinational rotate-priority search starting just after last_ptr.
// Zero latency; no state, so no backpressure of its own.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_ptr) + k) % NUM_CH;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N:1 valid/ready mux, explicit select or round-robin, registered output (1 cycle).
// A stalled output register drops every in_ready; STREAM_MUX_STATS_EN adds per-channel transfer counters.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
`ifdef STREAM_MUX_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [NUM_CH*STAT_CNT_W-1:0] stat_cnt
`endif
);

  mux_mode_e        mode_e;
  logic             load_en;
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_gnt_valid;
  logic [SEL_W-1:0] rr_gnt_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;
  logic [WIDTH-1:0] ch_dat [NUM_CH];

  assign mode_e  = mux_mode_e'(mode);
  assign load_en = !out_valid || out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_dat[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr (
    .req       (in_valid),
    .last_ptr  (rr_ptr),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // Select mode grants regardless of in_valid so a producer sees ready ahead of its beat.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (mode_e == MODE_RR) begin
      gnt_valid = rr_gnt_valid;
      gnt_idx   = rr_gnt_idx;
    end else begin
      gnt_valid = int'(sel) < NUM_CH;
      gnt_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = load_en && gnt_valid && (gnt_idx == SEL_W'(i));
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= ch_dat[gnt_idx];
        out_ch   <= gnt_idx;
        if (mode_e == MODE_RR) begin
          rr_ptr <= gnt_idx;
        end
      end
    end
  end

`ifdef STREAM_MUX_STATS_EN
  logic [STAT_CNT_W-1:0] stat_q [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q[i] <= '0;
      end else if (stat_clr) begin
        stat_q[i] <= '0;
      end else if (in_valid[i] && in_ready[i] && (stat_q[i] != '1)) begin
        stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
    assign stat_cnt[i*STAT_CNT_W +: STAT_CNT_W] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: a 4-channel instance driven from a vector table plus
// hand sequences (3-channel out-of-range select, async reset pulse, optional stats).
module tb_stream_mux_n;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

`ifdef STREAM_MUX_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_cnt;
  logic        stat_clr3;
  logic [47:0] stat_cnt3;
`endif

  int total;
  int bad;

  stream_mux_n #(.NUM_CH(4), .WIDTH(8)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef STREAM_MUX_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  stream_mux_n #(.NUM_CH(3), .WIDTH(8)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
`ifdef STREAM_MUX_STATS_EN
    ,
    .stat_clr  (stat_clr3),
    .stat_cnt  (stat_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [3:0]  exp_ready;
    logic        exp_ovld;
    logic [7:0]  exp_odat;
    logic [1:0]  exp_och;
  } vec_t;

  localparam logic [31:0] D_A = 32'h13A5_1110;
  localparam logic [31:0] D_B = 32'h1312_1110;
  localparam logic [31:0] D_C = 32'h1312_5510;

  vec_t vecs [17];

  initial begin
    total = 0;
    bad   = 0;

    // mode sel vld data ordy | in_ready ovld odat och
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, D_A, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, D_B, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, D_B, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, D_B, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, D_B, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, D_B, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1000, D_B, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[7]  = '{1'b1, 2'd0, 4'b1001, D_B, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[8]  = '{1'b1, 2'd0, 4'b1001, D_B, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[9]  = '{1'b0, 2'd1, 4'b0000, D_B, 1'b1, 4'b0010, 1'b0, 8'h13, 2'd3};
    vecs[10] = '{1'b0, 2'd1, 4'b0010, D_B, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[11] = '{1'b0, 2'd1, 4'b0010, D_C, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[12] = '{1'b0, 2'd1, 4'b0010, D_C, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{1'b0, 2'd1, 4'b0010, D_C, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[14] = '{1'b0, 2'd1, 4'b0010, D_C, 1'b1, 4'b0010, 1'b1, 8'h55, 2'd1};
    vecs[15] = '{1'b1, 2'd0, 4'b0000, D_B, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd1};
    vecs[16] = '{1'b1, 2'd0, 4'b0110, D_B, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

    rst_n      = 1'b0;
    mode       = 1'b0;
    sel        = 2'd0;
    in_valid   = 4'b0000;
    in_data    = 32'h0;
    out_ready  = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = 24'h22_21_20;
    out_ready3 = 1'b0;
`ifdef STREAM_MUX_STATS_EN
    stat_clr   = 1'b0;
    stat_clr3  = 1'b0;
`endif

    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'b0, out_data},  32'd0);
    chk("rst_out_ch",    {30'b0, out_ch},    32'd0);
    chk("rst_out_valid3", {31'b0, out_valid3}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_lookahead_ready", {28'b0, in_ready}, 32'b0001);
    chk("rst_ready3",          {29'b0, in_ready3}, 32'b001);

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      mode      = vecs[v].mode;
      sel       = vecs[v].sel;
      in_valid  = vecs[v].in_valid;
      in_data   = vecs[v].in_data;
      out_ready = vecs[v].out_ready;
      #1;
      chk($sformatf("v%0d_in_ready", v), {28'b0, in_ready}, {28'b0, vecs[v].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), {31'b0, out_valid}, {31'b0, vecs[v].exp_ovld});
      chk($sformatf("v%0d_out_data", v),  {24'b0, out_data},  {24'b0, vecs[v].exp_odat});
      chk($sformatf("v%0d_out_ch", v),    {30'b0, out_ch},    {30'b0, vecs[v].exp_och});
    end

    // 3-channel instance: out-of-range select drains the output and grants nothing
    @(negedge clk);
    mode3      = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    #1;
    chk("oor_pre_ready", {29'b0, in_ready3}, 32'b001);
    @(posedge clk);
    #1;
    chk("oor_pre_valid", {31'b0, out_valid3}, 32'd1);
    chk("oor_pre_data",  {24'b0, out_data3},  32'h20);
    @(negedge clk);
    sel3 = 2'd3;
    #1;
    chk("oor_ready", {29'b0, in_ready3}, 32'b000);
    @(posedge clk);
    #1;
    chk("oor_drained", {31'b0, out_valid3}, 32'd0);
    chk("oor_ch_hold", {30'b0, out_ch3},    32'd0);
    @(negedge clk);
    in_valid3 = 3'b000;

    // async reset pulse mid-stream, then round-robin restarts at ch0
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = D_B;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_ch",    {30'b0, out_ch},    32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_first_ready", {28'b0, in_ready}, 32'b0001);
    @(posedge clk);
    #1;
    chk("arst_first_ch",    {30'b0, out_ch},    32'd0);
    chk("arst_first_data",  {24'b0, out_data},  32'h10);
    chk("arst_first_valid", {31'b0, out_valid}, 32'd1);

`ifdef STREAM_MUX_STATS_EN
    @(negedge clk);
    in_valid = 4'b0000;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("stat_clr_idle", {16'b0, stat_cnt[15:0]}, 32'd0);
    @(negedge clk);
    stat_clr = 1'b0;
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    chk("stat_ch0_five", {16'b0, stat_cnt[15:0]},  32'd5);
    chk("stat_ch1_zero", {16'b0, stat_cnt[31:16]}, 32'd0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("stat_clr_prio", {16'b0, stat_cnt[15:0]}, 32'd0);
    @(negedge clk);
    stat_clr = 1'b0;
    in_valid = 4'b0000;
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
